// File: rtl/wb_commit_queue.sv
// ============================================================================
//  Module   : wb_commit_queue
//  Purpose  : In-order writeback commit queue feeding the register-file write
//             port, with a combinational youngest-match bypass lookup.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_commit_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PW    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n,
  input  logic                     wb_valid_i,
  output logic                     wb_ready_o,
  input  logic [AW-1:0]            wb_addr_i,
  input  logic [DW-1:0]            wb_data_i,
  input  logic [PW-1:0]            wb_pos_i,
  input  logic                     drain_en_i,
  input  logic                     flush_i,
  output logic                     RegWrite_o,
  output logic [AW-1:0]            RDaddr_o,
  output logic [DW-1:0]            RDdata_o,
  output logic [PW-1:0]            is_pos_o,
  input  logic [AW-1:0]            lk_addr_i,
  output logic                     lk_hit_o,
  output logic [DW-1:0]            lk_data_o,
  output logic [PW-1:0]            lk_pos_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    pos_q  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full_w, empty_w, push_w, pop_w;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  // Flush wins over both sides, so neither push nor pop fires in that cycle.
  assign push_w  = wb_valid_i & ~full_w & ~flush_i;
  assign pop_w   = ~empty_w & drain_en_i & ~flush_i;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_w) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PTRW'(1);
      end
      if (push_w) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PTRW'(1);
      end
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid/count.
  always_ff @(posedge clk_i) begin
    if (push_w) begin
      addr_q[wr_ptr_q] <= wb_addr_i;
      data_q[wr_ptr_q] <= wb_data_i;
      pos_q[wr_ptr_q]  <= wb_pos_i;
    end
  end

  assign wb_ready_o = ~full_w;
  assign empty_o    = empty_w;
  assign count_o    = count_q;
  assign RegWrite_o = pop_w;
  assign RDaddr_o   = empty_w ? '0 : addr_q[rd_ptr_q];
  assign RDdata_o   = empty_w ? '0 : data_q[rd_ptr_q];
  assign is_pos_o   = empty_w ? '0 : pos_q[rd_ptr_q];

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTRW-1:0] idx;
    lk_hit_o  = 1'b0;
    lk_data_o = '0;
    lk_pos_o  = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTRW'(i);
      if (valid_q[idx] && (addr_q[idx] == lk_addr_i)) begin
        lk_hit_o  = 1'b1;
        lk_data_o = data_q[idx];
        lk_pos_o  = pos_q[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
// ============================================================================
//  Module   : tb_wb_commit_queue
//  Purpose  : Self-checking bench for wb_commit_queue against a queue model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_commit_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int PW    = 4;

  logic          clk_i = 1'b0;
  logic          reset_n;
  logic          wb_valid_i, drain_en_i, flush_i;
  logic [AW-1:0] wb_addr_i, lk_addr_i;
  logic [DW-1:0] wb_data_i;
  logic [PW-1:0] wb_pos_i;
  logic          wb_ready_o, RegWrite_o, lk_hit_o, empty_o;
  logic [AW-1:0] RDaddr_o;
  logic [DW-1:0] RDdata_o, lk_data_o;
  logic [PW-1:0] is_pos_o, lk_pos_o;
  logic [$clog2(DEPTH):0] count_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } ent_t;
  ent_t mq[$];

  wb_commit_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_pos_i(wb_pos_i),
    .drain_en_i(drain_en_i), .flush_i(flush_i),
    .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
    .is_pos_o(is_pos_o), .lk_addr_i(lk_addr_i), .lk_hit_o(lk_hit_o),
    .lk_data_o(lk_data_o), .lk_pos_o(lk_pos_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the model implies for the current inputs.
  task automatic check_all(input string tag);
    logic          e_we, e_hit;
    logic [AW-1:0] e_ra;
    logic [DW-1:0] e_rd, e_ld;
    logic [PW-1:0] e_rp, e_lp;
    e_we = (mq.size() != 0) && drain_en_i && !flush_i && reset_n;
    e_ra = '0; e_rd = '0; e_rp = '0;
    if (mq.size() != 0) begin
      e_ra = mq[0].a; e_rd = mq[0].d; e_rp = mq[0].p;
    end
    e_hit = 1'b0; e_ld = '0; e_lp = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!e_hit && mq[i].a == lk_addr_i) begin
        e_hit = 1'b1; e_ld = mq[i].d; e_lp = mq[i].p;
      end
    end
    check({tag, ".ready"},  64'(wb_ready_o), 64'(mq.size() < DEPTH));
    check({tag, ".we"},     64'(RegWrite_o), 64'(e_we));
    check({tag, ".rdaddr"}, 64'(RDaddr_o),   64'(e_ra));
    check({tag, ".rddata"}, 64'(RDdata_o),   64'(e_rd));
    check({tag, ".ispos"},  64'(is_pos_o),   64'(e_rp));
    check({tag, ".hit"},    64'(lk_hit_o),   64'(e_hit));
    check({tag, ".lkdata"}, 64'(lk_data_o),  64'(e_ld));
    check({tag, ".lkpos"},  64'(lk_pos_o),   64'(e_lp));
    check({tag, ".count"},  64'(count_o),    64'(mq.size()));
    check({tag, ".empty"},  64'(empty_o),    64'(mq.size() == 0));
  endtask

  task automatic step(input string tag, input logic v, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [PW-1:0] p,
                      input logic dr, input logic fl, input logic [AW-1:0] la);
    logic can_push, do_pop;
    @(negedge clk_i);
    wb_valid_i = v; wb_addr_i = a; wb_data_i = d; wb_pos_i = p;
    drain_en_i = dr; flush_i = fl; lk_addr_i = la;
    #1;
    check_all(tag);
    can_push = v && (mq.size() < DEPTH);
    do_pop   = dr && (mq.size() != 0);
    @(posedge clk_i);
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (can_push) mq.push_back('{a: a, d: d, p: p});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wb_valid_i = 0; wb_addr_i = '0; wb_data_i = '0; wb_pos_i = '0;
    drain_en_i = 0; flush_i = 0; lk_addr_i = '0;
    #12;
    check_all("reset");
    @(negedge clk_i);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, 1, 0, 0);

    // Single enqueue then immediate commit
    step("enq1", 1, 5'd3, 32'hDEADBEEF, 4'd5, 1, 0, 5'd3);
    step("com1", 0, 0, 0, 0, 1, 0, 5'd3);
    step("emp1", 0, 0, 0, 0, 1, 0, 5'd3);

    // Fill to full (wrapping), refuse fifth beat, drain in order; twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 4; i++)
        step("fill", 1, 5'(i), 32'(i * 16 + r), 4'(i), 0, 0, 5'(i));
      step("full", 1, 5'd9, 32'h99, 4'd9, 0, 0, 5'd9);
      for (int i = 1; i <= 4; i++) step("drain", 0, 0, 0, 0, 1, 0, 5'd2);
      step("drained", 0, 0, 0, 0, 1, 0, 5'd2);
    end

    // Same address twice: youngest wins lookup, oldest commits first
    step("same1", 1, 5'd7, 32'h11, 4'd1, 0, 0, 5'd7);
    step("same2", 1, 5'd7, 32'h22, 4'd2, 0, 0, 5'd7);
    step("lk7",   0, 0, 0, 0, 0, 0, 5'd7);
    step("lk8",   0, 0, 0, 0, 0, 0, 5'd8);
    step("dr7a",  0, 0, 0, 0, 1, 0, 5'd7);
    step("dr7b",  0, 0, 0, 0, 1, 0, 5'd7);
    step("dr7c",  0, 0, 0, 0, 1, 0, 5'd7);

    // Flush with an incoming beat: beat dropped
    step("pre_fl", 1, 5'd1, 32'hA1, 4'd1, 0, 0, 5'd1);
    step("pre_fl", 1, 5'd2, 32'hA2, 4'd2, 0, 0, 5'd1);
    step("flush",  1, 5'd3, 32'hA3, 4'd3, 1, 1, 5'd3);
    step("post_fl", 0, 0, 0, 0, 1, 0, 5'd3);

    // Asynchronous reset mid-drain with three entries queued
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 5'(i), 32'(100 + i), 4'(i), 0, 0, 5'd0);
    @(negedge clk_i);
    wb_valid_i = 0; drain_en_i = 1; flush_i = 0; lk_addr_i = '0;
    #1;
    check_all("rst_before");
    #1;
    reset_n = 1'b0;
    mq.delete();
    #1;
    check_all("rst_async");
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 0, 0, 0, 0, 1, 0, 5'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom_range(0, 99) < 60),
           5'($urandom_range(0, 7)),
           $urandom,
           4'($urandom),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 4),
           5'($urandom_range(0, 8)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
